// File: rtl/bpfvm_ctrl_mc.sv
// Multi-cycle BPF VM controller: drives datapath selects/enables with configurable code/packet
// memory read latency, plus an instruction-count watchdog that rejects runaway filters.
module bpfvm_ctrl_mc #(
   parameter int CODE_LAT  = 1,
   parameter int PKT_LAT   = 1,
   parameter int MAX_INSTS = 4096,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_ready,
   input  logic [15:0]      opcode,
   input  logic             set,
   input  logic             eq,
   input  logic             gt,
   input  logic             ge,
   input  logic             A_is_zero,
   input  logic             X_is_zero,
   input  logic             imm_is_zero,
   output logic [2:0]       A_sel,
   output logic [2:0]       X_sel,
   output logic [1:0]       PC_sel,
   output logic             addr_sel,
   output logic             A_en,
   output logic             X_en,
   output logic             PC_en,
   output logic             PC_rst,
   output logic             B_sel,
   output logic [3:0]       ALU_sel,
   output logic [1:0]       transfer_sz,
   output logic             regfile_wr_en,
   output logic             regfile_sel,
   output logic             inst_mem_rd_en,
   output logic             packet_mem_rd_en,
   output logic             accept,
   output logic             reject,
   output logic             timeout,
   output logic             busy,
   output logic [CNT_W-1:0] inst_count
);

   // Instruction classes (opcode[2:0])
   localparam logic [2:0] BPF_LD   = 3'd0;
   localparam logic [2:0] BPF_LDX  = 3'd1;
   localparam logic [2:0] BPF_ST   = 3'd2;
   localparam logic [2:0] BPF_STX  = 3'd3;
   localparam logic [2:0] BPF_ALU  = 3'd4;
   localparam logic [2:0] BPF_JMP  = 3'd5;
   localparam logic [2:0] BPF_RET  = 3'd6;
   localparam logic [2:0] BPF_MISC = 3'd7;

   // Addressing modes (opcode[7:5])
   localparam logic [2:0] BPF_IMM = 3'd0;
   localparam logic [2:0] BPF_ABS = 3'd1;
   localparam logic [2:0] BPF_IND = 3'd2;
   localparam logic [2:0] BPF_MEM = 3'd3;
   localparam logic [2:0] BPF_LEN = 3'd4;
   localparam logic [2:0] BPF_MSH = 3'd5;

   // Jump operations (opcode[7:4])
   localparam logic [3:0] BPF_JA   = 4'd0;
   localparam logic [3:0] BPF_JEQ  = 4'd1;
   localparam logic [3:0] BPF_JGT  = 4'd2;
   localparam logic [3:0] BPF_JGE  = 4'd3;
   localparam logic [3:0] BPF_JSET = 4'd4;

   // Return value source (opcode[4:3])
   localparam logic [1:0] RET_K = 2'd0;
   localparam logic [1:0] RET_X = 2'd1;
   localparam logic [1:0] RET_A = 2'd2;

   localparam logic [2:0] A_SEL_IMM        = 3'd0;
   localparam logic [2:0] A_SEL_PACKET_MEM = 3'd1;
   localparam logic [2:0] A_SEL_LEN        = 3'd2;
   localparam logic [2:0] A_SEL_MEM        = 3'd3;
   localparam logic [2:0] A_SEL_ALU        = 3'd4;
   localparam logic [2:0] A_SEL_X          = 3'd5;

   localparam logic [2:0] X_SEL_IMM        = 3'd0;
   localparam logic [2:0] X_SEL_PACKET_MEM = 3'd1;
   localparam logic [2:0] X_SEL_LEN        = 3'd2;
   localparam logic [2:0] X_SEL_MEM        = 3'd3;
   localparam logic [2:0] X_SEL_MSH        = 3'd4;
   localparam logic [2:0] X_SEL_A          = 3'd5;

   localparam logic [1:0] PC_SEL_PLUS_1   = 2'd0;
   localparam logic [1:0] PC_SEL_PLUS_JT  = 2'd1;
   localparam logic [1:0] PC_SEL_PLUS_JF  = 2'd2;
   localparam logic [1:0] PC_SEL_PLUS_IMM = 2'd3;

   localparam logic PACK_ADDR_ABS = 1'b0;
   localparam logic PACK_ADDR_IND = 1'b1;
   localparam logic REGFILE_IN_A  = 1'b0;
   localparam logic REGFILE_IN_X  = 1'b1;

   localparam int LAT_MAX = (CODE_LAT > PKT_LAT) ? CODE_LAT : PKT_LAT;
   localparam int LAT_W   = $clog2(LAT_MAX + 1);
   localparam logic [LAT_W-1:0] CODE_LOAD = LAT_W'(CODE_LAT - 1);
   localparam logic [LAT_W-1:0] PKT_LOAD  = LAT_W'(PKT_LAT - 1);
   localparam logic [CNT_W-1:0] LAST_INST = CNT_W'(MAX_INSTS - 1);

   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE, S_PKT_WAIT,
      S_WR_MEM_A, S_WR_MEM_X, S_WR_MSH_X, S_WR_ALU_A
   } state_t;

   typedef enum logic [1:0] {PEND_A, PEND_X, PEND_MSH} pend_t;

   state_t           state_reg;
   pend_t            pend_reg;
   logic [LAT_W-1:0] wait_cnt_reg;
   logic [CNT_W-1:0] inst_count_reg;

   logic [2:0] cls;
   logic [2:0] mode;
   logic [3:0] jop;
   logic [1:0] rval;
   logic       unused_hi;

   assign cls       = opcode[2:0];
   assign mode      = opcode[7:5];
   assign jop       = opcode[7:4];
   assign rval      = opcode[4:3];
   assign unused_hi = ^opcode[15:8];

   // Opcode fields forwarded to the datapath regardless of state
   assign B_sel       = opcode[3];
   assign ALU_sel     = opcode[7:4];
   assign transfer_sz = opcode[4:3];
   assign addr_sel    = (mode == BPF_IND) ? PACK_ADDR_IND : PACK_ADDR_ABS;
   assign regfile_sel = (cls == BPF_STX) ? REGFILE_IN_X : REGFILE_IN_A;
   assign busy        = (state_reg != S_RESET);
   assign inst_count  = inst_count_reg;

   logic       d_A_en, d_X_en, d_PC_en, d_rf_wr, d_pkt_rd, d_accept, d_reject, d_is_ret;
   logic [2:0] d_A_sel, d_X_sel;
   logic [1:0] d_PC_sel;
   state_t     d_next;
   pend_t      d_pend;
   logic       ret_ok;
   logic       watchdog;
   state_t     pkt_dest;

   // Decode of the instruction currently on opcode; only consumed in DECODE
   always_comb begin
      d_A_en   = 1'b0;
      d_X_en   = 1'b0;
      d_PC_en  = 1'b0;
      d_rf_wr  = 1'b0;
      d_pkt_rd = 1'b0;
      d_accept = 1'b0;
      d_reject = 1'b0;
      d_is_ret = 1'b0;
      d_A_sel  = A_SEL_IMM;
      d_X_sel  = X_SEL_IMM;
      d_PC_sel = PC_SEL_PLUS_1;
      d_next   = S_FETCH;
      d_pend   = PEND_A;
      ret_ok   = 1'b0;
      case (cls)
         BPF_LD: begin
            case (mode)
               BPF_IMM: begin d_A_en = 1'b1; d_A_sel = A_SEL_IMM; end
               BPF_MEM: begin d_A_en = 1'b1; d_A_sel = A_SEL_MEM; end
               BPF_LEN: begin d_A_en = 1'b1; d_A_sel = A_SEL_LEN; end
               BPF_ABS, BPF_IND: begin
                  d_pkt_rd = 1'b1;
                  d_pend   = PEND_A;
                  d_next   = (PKT_LAT == 1) ? S_WR_MEM_A : S_PKT_WAIT;
               end
               default: begin d_reject = 1'b1; d_next = S_RESET; end
            endcase
         end
         BPF_LDX: begin
            case (mode)
               BPF_IMM: begin d_X_en = 1'b1; d_X_sel = X_SEL_IMM; end
               BPF_MEM: begin d_X_en = 1'b1; d_X_sel = X_SEL_MEM; end
               BPF_LEN: begin d_X_en = 1'b1; d_X_sel = X_SEL_LEN; end
               BPF_ABS, BPF_IND: begin
                  d_pkt_rd = 1'b1;
                  d_pend   = PEND_X;
                  d_next   = (PKT_LAT == 1) ? S_WR_MEM_X : S_PKT_WAIT;
               end
               BPF_MSH: begin
                  d_pkt_rd = 1'b1;
                  d_pend   = PEND_MSH;
                  d_next   = (PKT_LAT == 1) ? S_WR_MSH_X : S_PKT_WAIT;
               end
               default: begin d_reject = 1'b1; d_next = S_RESET; end
            endcase
         end
         BPF_ST, BPF_STX: d_rf_wr = 1'b1;
         BPF_ALU: d_next = S_WR_ALU_A;
         BPF_JMP: begin
            d_PC_en = 1'b1;
            case (jop)
               BPF_JA:   d_PC_sel = PC_SEL_PLUS_IMM;
               BPF_JEQ:  d_PC_sel = eq  ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
               BPF_JGT:  d_PC_sel = gt  ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
               BPF_JGE:  d_PC_sel = ge  ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
               BPF_JSET: d_PC_sel = set ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
               default: begin d_PC_en = 1'b0; d_reject = 1'b1; d_next = S_RESET; end
            endcase
         end
         BPF_RET: begin
            d_is_ret = 1'b1;
            case (rval)
               RET_K:   ret_ok = !imm_is_zero;
               RET_X:   ret_ok = !X_is_zero;
               RET_A:   ret_ok = !A_is_zero;
               default: ret_ok = 1'b0;
            endcase
            d_accept = ret_ok;
            d_reject = !ret_ok;
            d_next   = S_RESET;
         end
         default: begin
            // MISC: only TAX (0x07) and TXA (0x87) exist
            if (opcode[7:3] == 5'b00000) begin
               d_X_en  = 1'b1;
               d_X_sel = X_SEL_A;
            end else if (opcode[7:3] == 5'b10000) begin
               d_A_en  = 1'b1;
               d_A_sel = A_SEL_X;
            end else begin
               d_reject = 1'b1;
               d_next   = S_RESET;
            end
         end
      endcase
   end

   // A RET landing on the last allowed instruction still gets its normal verdict
   assign watchdog = (state_reg == S_DECODE) && (inst_count_reg == LAST_INST) && !d_is_ret;

   always_comb begin
      case (pend_reg)
         PEND_X:   pkt_dest = S_WR_MEM_X;
         PEND_MSH: pkt_dest = S_WR_MSH_X;
         default:  pkt_dest = S_WR_MEM_A;
      endcase
   end

   always_comb begin
      A_sel            = A_SEL_IMM;
      X_sel            = X_SEL_IMM;
      PC_sel           = PC_SEL_PLUS_1;
      A_en             = 1'b0;
      X_en             = 1'b0;
      PC_en            = 1'b0;
      PC_rst           = 1'b0;
      regfile_wr_en    = 1'b0;
      inst_mem_rd_en   = 1'b0;
      packet_mem_rd_en = 1'b0;
      accept           = 1'b0;
      reject           = 1'b0;
      timeout          = 1'b0;
      case (state_reg)
         S_RESET: PC_rst = 1'b1;
         S_FETCH: begin
            inst_mem_rd_en = 1'b1;
            PC_en          = 1'b1;
            PC_sel         = PC_SEL_PLUS_1;
         end
         S_DECODE: begin
            if (watchdog) begin
               reject  = 1'b1;
               timeout = 1'b1;
            end else begin
               A_sel            = d_A_sel;
               X_sel            = d_X_sel;
               PC_sel           = d_PC_sel;
               A_en             = d_A_en;
               X_en             = d_X_en;
               PC_en            = d_PC_en;
               regfile_wr_en    = d_rf_wr;
               packet_mem_rd_en = d_pkt_rd;
               accept           = d_accept;
               reject           = d_reject;
            end
         end
         S_WR_MEM_A: begin A_en = 1'b1; A_sel = A_SEL_PACKET_MEM; end
         S_WR_MEM_X: begin X_en = 1'b1; X_sel = X_SEL_PACKET_MEM; end
         S_WR_MSH_X: begin X_en = 1'b1; X_sel = X_SEL_MSH; end
         S_WR_ALU_A: begin A_en = 1'b1; A_sel = A_SEL_ALU; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_RESET;
         pend_reg       <= PEND_A;
         wait_cnt_reg   <= '0;
         inst_count_reg <= '0;
      end else begin
         case (state_reg)
            S_RESET: begin
               if (mem_ready) begin
                  state_reg      <= S_FETCH;
                  inst_count_reg <= '0;
               end
            end
            S_FETCH: begin
               wait_cnt_reg <= CODE_LOAD;
               state_reg    <= (CODE_LAT == 1) ? S_DECODE : S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
               if (wait_cnt_reg <= LAT_W'(1)) state_reg <= S_DECODE;
               else wait_cnt_reg <= wait_cnt_reg - LAT_W'(1);
            end
            S_DECODE: begin
               if (inst_count_reg != {CNT_W{1'b1}})
                  inst_count_reg <= inst_count_reg + CNT_W'(1);
               pend_reg     <= d_pend;
               wait_cnt_reg <= PKT_LOAD;
               state_reg    <= watchdog ? S_RESET : d_next;
            end
            S_PKT_WAIT: begin
               if (wait_cnt_reg <= LAT_W'(1)) state_reg <= pkt_dest;
               else wait_cnt_reg <= wait_cnt_reg - LAT_W'(1);
            end
            S_WR_MEM_A, S_WR_MEM_X, S_WR_MSH_X, S_WR_ALU_A: state_reg <= S_FETCH;
            default: state_reg <= S_RESET;
         endcase
      end
   end

endmodule

// File: tb/tb_bpfvm_ctrl_mc.sv
// Directed bench for bpfvm_ctrl_mc: three instances with different latency/watchdog settings
// share stimulus; the instance under test is released from reset while the others stay held.
module tb_bpfvm_ctrl_mc;

   logic        clk = 1'b0;
   logic [2:0]  rst_v;
   logic        mem_ready;
   logic [15:0] opcode;
   logic        set, eq, gt, ge, A_is_zero, X_is_zero, imm_is_zero;

   logic [2:0]  A_sel_w [3];
   logic [2:0]  X_sel_w [3];
   logic [1:0]  PC_sel_w [3];
   logic        addr_sel_w [3];
   logic        A_en_w [3];
   logic        X_en_w [3];
   logic        PC_en_w [3];
   logic        PC_rst_w [3];
   logic        B_sel_w [3];
   logic [3:0]  ALU_sel_w [3];
   logic [1:0]  transfer_sz_w [3];
   logic        regfile_wr_en_w [3];
   logic        regfile_sel_w [3];
   logic        inst_mem_rd_en_w [3];
   logic        packet_mem_rd_en_w [3];
   logic        accept_w [3];
   logic        reject_w [3];
   logic        timeout_w [3];
   logic        busy_w [3];
   logic [15:0] inst_count_w [3];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // g_dut[0]: CODE_LAT=1 PKT_LAT=1 MAX_INSTS=4; [1]: 3/4/4096; [2]: 1/5/4096
   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int CL = (gi == 1) ? 3 : 1;
      localparam int PL = (gi == 1) ? 4 : ((gi == 2) ? 5 : 1);
      localparam int MI = (gi == 0) ? 4 : 4096;
      bpfvm_ctrl_mc #(.CODE_LAT(CL), .PKT_LAT(PL), .MAX_INSTS(MI), .CNT_W(16)) u_dut (
         .clk(clk), .rst(rst_v[gi]), .mem_ready(mem_ready), .opcode(opcode),
         .set(set), .eq(eq), .gt(gt), .ge(ge),
         .A_is_zero(A_is_zero), .X_is_zero(X_is_zero), .imm_is_zero(imm_is_zero),
         .A_sel(A_sel_w[gi]), .X_sel(X_sel_w[gi]), .PC_sel(PC_sel_w[gi]),
         .addr_sel(addr_sel_w[gi]), .A_en(A_en_w[gi]), .X_en(X_en_w[gi]),
         .PC_en(PC_en_w[gi]), .PC_rst(PC_rst_w[gi]), .B_sel(B_sel_w[gi]),
         .ALU_sel(ALU_sel_w[gi]), .transfer_sz(transfer_sz_w[gi]),
         .regfile_wr_en(regfile_wr_en_w[gi]), .regfile_sel(regfile_sel_w[gi]),
         .inst_mem_rd_en(inst_mem_rd_en_w[gi]), .packet_mem_rd_en(packet_mem_rd_en_w[gi]),
         .accept(accept_w[gi]), .reject(reject_w[gi]), .timeout(timeout_w[gi]),
         .busy(busy_w[gi]), .inst_count(inst_count_w[gi])
      );
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) begin
         $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; the new opcode settles before outputs are sampled
   task automatic step(input logic [15:0] op);
      @(posedge clk);
      #1;
      opcode = op;
      #1;
   endtask

   initial begin
      rst_v = 3'b111; mem_ready = 1'b0; opcode = 16'h00B1;
      set = 0; eq = 0; gt = 0; ge = 0; A_is_zero = 0; X_is_zero = 0; imm_is_zero = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_pc_rst", PC_rst_w[0], 1);
      chk("rst_busy", busy_w[0], 0);
      chk("rst_inst_count", inst_count_w[0], 0);
      chk("rst_A_en", A_en_w[0], 0);
      chk("rst_transfer_sz", transfer_sz_w[0], 2);
      chk("rst_ALU_sel", ALU_sel_w[0], 11);

      // LD IMM 5 ; RET A with unit latencies
      rst_v[0] = 1'b0; mem_ready = 1'b1; opcode = 16'h0000;
      step(16'h0000); mem_ready = 1'b0;
      chk("t1_fetch_imem", inst_mem_rd_en_w[0], 1);
      chk("t1_fetch_pc_en", PC_en_w[0], 1);
      chk("t1_fetch_pc_rst", PC_rst_w[0], 0);
      chk("t1_fetch_busy", busy_w[0], 1);
      step(16'h0000);
      chk("t1_dec_A_en", A_en_w[0], 1);
      chk("t1_dec_A_sel", A_sel_w[0], 0);
      chk("t1_dec_imem", inst_mem_rd_en_w[0], 0);
      step(16'h0016);
      chk("t1_fetch2_imem", inst_mem_rd_en_w[0], 1);
      chk("t1_fetch2_cnt", inst_count_w[0], 1);
      step(16'h0016);
      chk("t1_ret_accept", accept_w[0], 1);
      chk("t1_ret_reject", reject_w[0], 0);
      step(16'h0016);
      chk("t1_end_accept", accept_w[0], 0);
      chk("t1_end_busy", busy_w[0], 0);
      chk("t1_end_cnt", inst_count_w[0], 2);

      // LDX MSH ; JEQ (eq=0 then eq=1)
      mem_ready = 1'b1;
      step(16'h00B1); mem_ready = 1'b0;
      chk("t3_fetch_cnt_clr", inst_count_w[0], 0);
      step(16'h00B1);
      chk("t3_dec_pkt_rd", packet_mem_rd_en_w[0], 1);
      chk("t3_dec_X_en", X_en_w[0], 0);
      chk("t3_dec_addr_sel", addr_sel_w[0], 0);
      step(16'h00B1);
      chk("t3_msh_X_en", X_en_w[0], 1);
      chk("t3_msh_X_sel", X_sel_w[0], 4);
      chk("t3_msh_pkt_rd", packet_mem_rd_en_w[0], 0);
      step(16'h0015);
      step(16'h0015);
      chk("t3_jeq_pc_en", PC_en_w[0], 1);
      chk("t3_jeq_jf", PC_sel_w[0], 2);
      chk("t3_jeq_alu_sel", ALU_sel_w[0], 1);
      eq = 1'b1; #1;
      chk("t3_jeq_jt", PC_sel_w[0], 1);
      eq = 1'b0;
      rst_v[0] = 1'b1;
      step(16'h0005);
      chk("t3_rst_pc_rst", PC_rst_w[0], 1);
      rst_v[0] = 1'b0;

      // Infinite JA loop against MAX_INSTS=4
      mem_ready = 1'b1;
      step(16'h0005); mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(16'h0005);
         chk("t4_ja_pc_en", PC_en_w[0], 1);
         chk("t4_ja_pc_sel", PC_sel_w[0], 3);
         chk("t4_ja_reject", reject_w[0], 0);
         step(16'h0005);
      end
      step(16'h0005);
      chk("t4_wd_cnt", inst_count_w[0], 3);
      chk("t4_wd_pc_en", PC_en_w[0], 0);
      chk("t4_wd_reject", reject_w[0], 1);
      chk("t4_wd_timeout", timeout_w[0], 1);
      chk("t4_wd_accept", accept_w[0], 0);
      step(16'h0005);
      chk("t4_post_busy", busy_w[0], 0);
      chk("t4_post_timeout", timeout_w[0], 0);
      chk("t4_post_cnt", inst_count_w[0], 4);

      // RET K on the watchdog instruction keeps its verdict
      mem_ready = 1'b1;
      step(16'h0005); mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(16'h0005);
         step(16'h0006);
      end
      step(16'h0006);
      chk("t4b_ret_accept", accept_w[0], 1);
      chk("t4b_ret_timeout", timeout_w[0], 0);
      chk("t4b_ret_reject", reject_w[0], 0);
      step(16'h0006);
      chk("t4b_post_busy", busy_w[0], 0);
      rst_v[0] = 1'b1;

      // CODE_LAT=3 PKT_LAT=4: LD ABS ; RET A with A==0
      rst_v[1] = 1'b0; mem_ready = 1'b1; A_is_zero = 1'b1;
      step(16'h0020); mem_ready = 1'b0;
      chk("t2_fetch_imem", inst_mem_rd_en_w[1], 1);
      step(16'h0020);
      chk("t2_fw1_imem", inst_mem_rd_en_w[1], 0);
      chk("t2_fw1_pc_en", PC_en_w[1], 0);
      chk("t2_fw1_busy", busy_w[1], 1);
      step(16'h0020);
      chk("t2_fw2_pkt_rd", packet_mem_rd_en_w[1], 0);
      step(16'h0020);
      chk("t2_dec_pkt_rd", packet_mem_rd_en_w[1], 1);
      chk("t2_dec_A_en", A_en_w[1], 0);
      chk("t2_dec_addr_sel", addr_sel_w[1], 0);
      for (int i = 0; i < 3; i++) begin
         step(16'h0020);
         chk("t2_pw_A_en", A_en_w[1], 0);
         chk("t2_pw_pkt_rd", packet_mem_rd_en_w[1], 0);
      end
      step(16'h0016);
      chk("t2_wr_A_en", A_en_w[1], 1);
      chk("t2_wr_A_sel", A_sel_w[1], 1);
      step(16'h0016);
      chk("t2_fetch2_imem", inst_mem_rd_en_w[1], 1);
      step(16'h0016);
      step(16'h0016);
      chk("t2_fw_accept", accept_w[1], 0);
      step(16'h0016);
      chk("t2_ret_reject", reject_w[1], 1);
      chk("t2_ret_accept", accept_w[1], 0);
      step(16'h0016);
      chk("t2_end_busy", busy_w[1], 0);
      chk("t2_end_cnt", inst_count_w[1], 2);
      A_is_zero = 1'b0;

      // Illegal LDX addressing mode 6
      mem_ready = 1'b1;
      step(16'h00C1); mem_ready = 1'b0;
      step(16'h00C1);
      step(16'h00C1);
      step(16'h00C1);
      chk("t6_ill_reject", reject_w[1], 1);
      chk("t6_ill_timeout", timeout_w[1], 0);
      chk("t6_ill_X_en", X_en_w[1], 0);
      chk("t6_ill_accept", accept_w[1], 0);
      step(16'h00C1);
      chk("t6_post_busy", busy_w[1], 0);
      chk("t6_post_pc_rst", PC_rst_w[1], 1);
      rst_v[1] = 1'b1;

      // PKT_LAT=5: rst during PKT_WAIT, then clean restart
      rst_v[2] = 1'b0; mem_ready = 1'b1;
      step(16'h0040); mem_ready = 1'b0;
      step(16'h0040);
      chk("t5_dec_pkt_rd", packet_mem_rd_en_w[2], 1);
      chk("t5_dec_addr_ind", addr_sel_w[2], 1);
      step(16'h0040);
      step(16'h0040);
      chk("t5_pw_A_en", A_en_w[2], 0);
      rst_v[2] = 1'b1;
      step(16'h0040);
      chk("t5_rst_pc_rst", PC_rst_w[2], 1);
      chk("t5_rst_busy", busy_w[2], 0);
      rst_v[2] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(16'h0040);
         chk("t5_idle_A_en", A_en_w[2], 0);
         chk("t5_idle_X_en", X_en_w[2], 0);
         chk("t5_idle_busy", busy_w[2], 0);
      end
      mem_ready = 1'b1;
      step(16'h0040); mem_ready = 1'b0;
      chk("t5_re_busy", busy_w[2], 1);
      step(16'h0040);
      chk("t5_re_pkt_rd", packet_mem_rd_en_w[2], 1);
      for (int i = 0; i < 4; i++) begin
         step(16'h0040);
         chk("t5_re_pw_A_en", A_en_w[2], 0);
      end
      step(16'h0006);
      chk("t5_re_wr_A_en", A_en_w[2], 1);
      chk("t5_re_wr_A_sel", A_sel_w[2], 1);
      imm_is_zero = 1'b1;
      step(16'h0006);
      step(16'h0006);
      chk("t5_ret_reject", reject_w[2], 1);
      chk("t5_ret_accept", accept_w[2], 0);
      step(16'h0006);
      chk("t5_end_busy", busy_w[2], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
